// File: rtl/b_tile_addr_gen.sv
// B-operand address generator: walks B row by row in BUS_DATA-wide column
// blocks, repeating the walk once per ARRAY_HEIGHT-row tile of A.
module b_tile_addr_gen #(
  parameter int ARRAY_HEIGHT  = 4,
  parameter int BUS_WIDTH     = 256,
  parameter int ELEMENT_BYTES = 1,
  parameter int ADDR_WIDTH    = 16,
  parameter int DIM_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [DIM_WIDTH-1:0]  m,
  input  logic [DIM_WIDTH-1:0]  n,
  input  logic [DIM_WIDTH-1:0]  p,
  input  logic [ADDR_WIDTH-1:0] base_addr_b,
  input  logic [ADDR_WIDTH-1:0] row_stride,
  output logic [ADDR_WIDTH-1:0] b_fifo_addr,
  output logic [BUS_WIDTH/(8*ELEMENT_BYTES)-1:0] b_fifo_mask,
  output logic                  b_fifo_last,
  output logic                  b_fifo_incr,
  input  logic                  b_fifo_full,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int BUS_DATA = BUS_WIDTH / (8 * ELEMENT_BYTES);
  localparam int AH_LOG   = $clog2(ARRAY_HEIGHT);

  localparam logic [ADDR_WIDTH-1:0] BLK_BYTES =
    ADDR_WIDTH'(BUS_DATA * ELEMENT_BYTES);
  localparam logic [DIM_WIDTH-1:0] BD_N  = DIM_WIDTH'(BUS_DATA);
  localparam logic [DIM_WIDTH:0]   BD_W  = (DIM_WIDTH+1)'(BUS_DATA);
  localparam logic [DIM_WIDTH:0]   BD_M1 = (DIM_WIDTH+1)'(BUS_DATA - 1);
  localparam logic [DIM_WIDTH:0]   AH_M1 = (DIM_WIDTH+1)'(ARRAY_HEIGHT - 1);
  localparam logic [DIM_WIDTH-1:0] ONE_N = 1;
  localparam logic [DIM_WIDTH:0]   ONE_W = 1;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    FINISH
  } state_t;

  state_t state_q, state_d;

  logic [DIM_WIDTH-1:0]  n_q, p_q, row_q, rem_q;
  logic [DIM_WIDTH:0]    nc_q, nr_q, cblk_q, rep_q;
  logic [ADDR_WIDTH-1:0] base_q, stride_q, blk_q, cur_q;
  logic                  zero_q;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BUS_DATA-1:0]   mask_q, mask_w;
  logic                  last_q, incr_q;

  logic [DIM_WIDTH:0] nc_w, nr_w;
  logic row_end, blk_end, rep_end;
  logic emit, accept;

  // Block and tile counts are fixed per walk, so divide once at start.
  assign nc_w = ({1'b0, p} + BD_M1) / BD_W;
  assign nr_w = ({1'b0, m} + AH_M1) >> AH_LOG;

  assign row_end = row_q == (n_q - ONE_N);
  assign blk_end = cblk_q == (nc_q - ONE_W);
  assign rep_end = rep_q == (nr_q - ONE_W);

  always_comb begin
    mask_w = '0;
    for (int i = 0; i < BUS_DATA; i++)
      mask_w[i] = DIM_WIDTH'(i) < rem_q;
  end

  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          state_d = EMIT;
          accept  = 1'b1;
        end
      end
      EMIT: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (zero_q) begin
          state_d = FINISH;
        end else if (!b_fifo_full) begin
          emit = 1'b1;
          if (row_end && blk_end && rep_end)
            state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      n_q      <= '0;
      p_q      <= '0;
      row_q    <= '0;
      rem_q    <= '0;
      nc_q     <= '0;
      nr_q     <= '0;
      cblk_q   <= '0;
      rep_q    <= '0;
      base_q   <= '0;
      stride_q <= '0;
      blk_q    <= '0;
      cur_q    <= '0;
      zero_q   <= 1'b0;
      addr_q   <= '0;
      mask_q   <= '0;
      last_q   <= 1'b0;
      incr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      incr_q  <= emit;
      if (accept) begin
        n_q      <= n;
        p_q      <= p;
        nc_q     <= nc_w;
        nr_q     <= nr_w;
        base_q   <= base_addr_b;
        stride_q <= row_stride;
        zero_q   <= (m == '0) || (n == '0) || (p == '0);
        row_q    <= '0;
        cblk_q   <= '0;
        rep_q    <= '0;
        rem_q    <= p;
        blk_q    <= base_addr_b;
        cur_q    <= base_addr_b;
      end
      if (emit) begin
        addr_q <= cur_q;
        mask_q <= mask_w;
        last_q <= row_end;
        if (!row_end) begin
          row_q <= row_q + ONE_N;
          cur_q <= cur_q + stride_q;
        end else begin
          row_q <= '0;
          if (!blk_end) begin
            cblk_q <= cblk_q + ONE_W;
            blk_q  <= blk_q + BLK_BYTES;
            cur_q  <= blk_q + BLK_BYTES;
            rem_q  <= rem_q - BD_N;
          end else begin
            // Next tile of A: replay B from the top.
            cblk_q <= '0;
            blk_q  <= base_q;
            cur_q  <= base_q;
            rem_q  <= p_q;
            rep_q  <= rep_q + ONE_W;
          end
        end
      end
    end
  end

  assign b_fifo_addr = addr_q;
  assign b_fifo_mask = mask_q;
  assign b_fifo_last = last_q;
  assign b_fifo_incr = incr_q;
  assign busy_o      = state_q == EMIT;
  assign done_o      = state_q == FINISH;

endmodule
